// File: rtl/mcs4_bus_sequencer.sv
// MCS-4 bus master: free-running A1..X3 phase generator that executes one host command
// (ROM read, RAM SRC/RDM/WRM) per instruction cycle against i4001/i4002 parts.
module mcs4_bus_sequencer #(
   parameter int PHASE_CLKS = 1
) (
   input  logic        clk,
   input  logic        res_n,
   input  logic        cmd_vld,
   output logic        cmd_rdy,
   input  logic [1:0]  cmd_op,
   input  logic [11:0] cmd_addr,
   input  logic [2:0]  cmd_bank,
   input  logic [3:0]  cmd_wdata,
   output logic        rsp_vld,
   output logic [7:0]  rsp_data,
   output logic        sync_n,
   output logic        cm_rom_n,
   output logic [3:0]  cm_ram_n,
   input  logic [3:0]  data_i,
   output logic [3:0]  data_o,
   output logic        data_oe
);
   typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;
   typedef enum logic [1:0] {ROM_RD, RAM_SRC, RAM_RDM, RAM_WRM} op_t;

   localparam int TW = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;
   localparam logic [TW-1:0] TMR_LAST = TW'(PHASE_CLKS - 1);

   phase_t        ph, ph_nx;
   logic [TW-1:0] tmr, tmr_nx;
   logic          run, busy;
   logic          ph_end, x3_end, accept;
   op_t           op_q;
   logic [11:0]   addr_q;
   logic [2:0]    bank_q;
   logic [3:0]    wd_q;
   logic [3:0]    bank_code;
   logic [7:0]    dat_q, hold_q;

   // run holds the timer still for the first clock after reset so X3 gets a full phase
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         ph     <= X3;
         tmr    <= '0;
         run    <= 1'b0;
         busy   <= 1'b0;
         op_q   <= ROM_RD;
         addr_q <= '0;
         bank_q <= '0;
         wd_q   <= '0;
         dat_q  <= '0;
         hold_q <= '0;
      end else begin
         run <= 1'b1;
         ph  <= ph_nx;
         tmr <= tmr_nx;
         if (x3_end) busy <= cmd_vld;
         if (accept) begin
            op_q   <= op_t'(cmd_op);
            addr_q <= cmd_addr;
            bank_q <= cmd_bank;
            wd_q   <= cmd_wdata;
            dat_q  <= '0;
         end else if (busy && ph_end) begin
            if (ph == M1 && op_q == ROM_RD) dat_q[7:4] <= data_i;
            if (ph == M2 && op_q == ROM_RD) dat_q[3:0] <= data_i;
            if (ph == X2 && op_q == RAM_RDM) dat_q <= {4'h0, data_i};
         end
         if (rsp_vld) hold_q <= dat_q;
      end
   end

   always_comb begin
      ph_end = run && (tmr == TMR_LAST);
      ph_nx  = ph;
      tmr_nx = tmr;
      if (run) begin
         if (ph_end) begin
            tmr_nx = '0;
            ph_nx  = phase_t'(ph + 3'd1);
         end else begin
            tmr_nx = tmr + 1'b1;
         end
      end
      x3_end   = ph_end && (ph == X3);
      accept   = x3_end && cmd_vld;
      cmd_rdy  = x3_end;
      rsp_vld  = x3_end && busy;
      rsp_data = rsp_vld ? dat_q : hold_q;

      case (bank_q)
         3'd0:    bank_code = 4'b1110;
         3'd1:    bank_code = 4'b1101;
         3'd2:    bank_code = 4'b1011;
         3'd3:    bank_code = 4'b1001;
         3'd4:    bank_code = 4'b0111;
         3'd5:    bank_code = 4'b0101;
         3'd6:    bank_code = 4'b0011;
         default: bank_code = 4'b0001;
      endcase

      sync_n   = !(run && ph == X3);
      cm_rom_n = 1'b1;
      cm_ram_n = 4'hF;
      data_oe  = 1'b0;
      data_o   = 4'h0;
      // X1 is always a turnaround phase, so it has no branch here
      if (busy) begin
         case (ph)
            A1: begin data_oe = 1'b1; data_o = addr_q[3:0];  end
            A2: begin data_oe = 1'b1; data_o = addr_q[7:4];  end
            A3: begin
               data_oe  = 1'b1;
               data_o   = addr_q[11:8];
               cm_rom_n = (op_q != ROM_RD);
            end
            M1: if (op_q != ROM_RD) begin
               data_oe = 1'b1;
               data_o  = (op_q == RAM_SRC) ? 4'h2 : 4'hE;
            end
            M2: case (op_q)
               RAM_SRC: begin data_oe = 1'b1; data_o = 4'h1; end
               RAM_RDM: begin data_oe = 1'b1; data_o = 4'h9; cm_ram_n = bank_code; end
               RAM_WRM: begin data_oe = 1'b1; data_o = 4'h0; cm_ram_n = bank_code; end
               default: ;
            endcase
            X2: case (op_q)
               RAM_SRC: begin data_oe = 1'b1; data_o = addr_q[7:4]; cm_ram_n = bank_code; end
               RAM_WRM: begin data_oe = 1'b1; data_o = wd_q; end
               default: ;
            endcase
            X3: if (op_q == RAM_SRC) begin
               data_oe = 1'b1;
               data_o  = addr_q[3:0];
            end
            default: ;
         endcase
      end
   end
endmodule
